// File: rtl/barrel_pkg.sv
// Shared op-code encodings and decode helper for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One shifter stage: conditionally shift by SHIFT, then register everything under adv.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic             i_err,
  input  logic             i_fill,
  input  logic [2:0]       i_op,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_fill,
  output logic [2:0]       o_op,
  output logic [AMT_W-1:0] o_amt,
  output logic [WIDTH-1:0] o_data
);

  localparam int BIT = $clog2(SHIFT);

  logic [WIDTH-1:0] w_shifted;

  // Illegal ops fall to the default arm and pass data through untouched.
  always_comb begin
    w_shifted = i_data;
    if (i_amt[BIT]) begin
      case (i_op)
        OP_SLL:  w_shifted = {i_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        OP_SRL:  w_shifted = {{SHIFT{1'b0}}, i_data[WIDTH-1:SHIFT]};
        OP_SRA:  w_shifted = {{SHIFT{i_fill}}, i_data[WIDTH-1:SHIFT]};
        OP_ROL:  w_shifted = {i_data[WIDTH-SHIFT-1:0], i_data[WIDTH-1:WIDTH-SHIFT]};
        OP_ROR:  w_shifted = {i_data[SHIFT-1:0], i_data[WIDTH-1:SHIFT]};
        default: w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_fill  <= 1'b0;
      o_op    <= '0;
      o_amt   <= '0;
      o_data  <= '0;
    end else if (i_adv) begin
      o_valid <= i_valid;
      o_err   <= i_err;
      o_fill  <= i_fill;
      o_op    <= i_op;
      o_amt   <= i_amt;
      o_data  <= w_shifted;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, global stall on back-pressure.
// Handshake: a transfer occurs on a rising edge where valid & ready are both 1; in_ready = !out_valid | out_ready.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic                  w_adv;
  logic [SHAMT_W:0]      w_valid;
  logic [SHAMT_W:0]      w_err;
  logic [SHAMT_W:0]      w_fill;
  logic [2:0]            w_op   [SHAMT_W+1];
  logic [SHAMT_W-1:0]    w_amt  [SHAMT_W+1];
  logic [WIDTH-1:0]      w_data [SHAMT_W+1];
  logic [SHAMT_W+3:0]    w_unused_tail;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // The SRA fill bit is latched from the original MSB so every stage sees the true sign.
  assign w_valid[0] = in_valid;
  assign w_err[0]   = !op_is_legal(in_op);
  assign w_fill[0]  = in_data[WIDTH-1];
  assign w_op[0]    = in_op;
  assign w_amt[0]   = in_amt;
  assign w_data[0]  = in_data;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k),
      .AMT_W (SHAMT_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_valid (w_valid[k]),
      .i_err   (w_err[k]),
      .i_fill  (w_fill[k]),
      .i_op    (w_op[k]),
      .i_amt   (w_amt[k]),
      .i_data  (w_data[k]),
      .o_valid (w_valid[k+1]),
      .o_err   (w_err[k+1]),
      .o_fill  (w_fill[k+1]),
      .o_op    (w_op[k+1]),
      .o_amt   (w_amt[k+1]),
      .o_data  (w_data[k+1])
    );
  end

  assign out_valid = w_valid[SHAMT_W];
  assign out_err   = w_err[SHAMT_W];
  assign out_data  = w_data[SHAMT_W];

  // Sideband leaving the last stage has no consumer.
  assign w_unused_tail = {w_fill[SHAMT_W], w_op[SHAMT_W], w_amt[SHAMT_W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at WIDTH 8 and WIDTH 32.
module tb_barrel_shifter_pipe;
  import barrel_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT, WIDTH = 8 ----------------
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0] in_data, out_data;
  logic [2:0] in_amt, in_op;

  barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // ---------------- DUT, WIDTH = 32 ----------------
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_err_w;
  logic [31:0] in_data_w, out_data_w;
  logic [4:0]  in_amt_w;
  logic [2:0]  in_op_w;

  barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .in_data   (in_data_w),
    .in_amt    (in_amt_w),
    .in_op     (in_op_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .out_data  (out_data_w),
    .out_err   (out_err_w)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (WIDTH = 8) ----------------
  logic [8:0] exp_q[$];
  int         stamp_q[$];
  bit         chk_lat = 1'b1;
  logic [8:0] sb_exp;
  int         sb_stamp;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none", {out_err, out_data});
      end else begin
        sb_exp   = exp_q.pop_front();
        sb_stamp = stamp_q.pop_front();
        check("result", {out_err, out_data}, sb_exp);
        if (chk_lat) check("latency", cyc - sb_stamp, 3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                      input logic [8:0] exp);
    int w = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = data;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("send_accept", in_ready, 1);
    if (in_ready) begin
      exp_q.push_back(exp);
      stamp_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    send(v.op, v.amt, v.data, {v.exp_err, v.exp_data});
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && w < 30) begin
      w++;
      @(negedge clk);
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] data,
                        input logic [31:0] exp);
    int c0;
    int w = 0;
    in_valid_w = 1'b1;
    in_op_w    = op;
    in_amt_w   = amt;
    in_data_w  = data;
    @(negedge clk);
    check("w32_in_ready", in_ready_w, 1);
    c0 = cyc;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    @(negedge clk);
    while (!out_valid_w && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("w32_latency", cyc - c0, 5);
    check("w32_data", out_data_w, exp);
    check("w32_err", out_err_w, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t       vecs[22];
  logic [8:0] held;

  initial begin
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    in_valid_w = 1'b0; in_data_w = '0; in_amt_w = '0; in_op_w = '0; out_ready_w = 1'b1;

    vecs[0]  = '{OP_ROL, 3'd0, 8'hCC, 8'hCC, 1'b0};
    vecs[1]  = '{OP_ROL, 3'd1, 8'hCC, 8'h99, 1'b0};
    vecs[2]  = '{OP_ROL, 3'd2, 8'hCC, 8'h33, 1'b0};
    vecs[3]  = '{OP_ROL, 3'd3, 8'hCC, 8'h66, 1'b0};
    vecs[4]  = '{OP_ROL, 3'd4, 8'hCC, 8'hCC, 1'b0};
    vecs[5]  = '{OP_ROL, 3'd5, 8'hCC, 8'h99, 1'b0};
    vecs[6]  = '{OP_ROL, 3'd6, 8'hCC, 8'h33, 1'b0};
    vecs[7]  = '{OP_ROL, 3'd7, 8'hCC, 8'h66, 1'b0};
    vecs[8]  = '{OP_ROR, 3'd3, 8'hCC, 8'h99, 1'b0};
    vecs[9]  = '{OP_SRA, 3'd2, 8'hCC, 8'hF3, 1'b0};
    vecs[10] = '{OP_SRL, 3'd7, 8'hCC, 8'h01, 1'b0};
    vecs[11] = '{OP_SLL, 3'd7, 8'hCC, 8'h00, 1'b0};
    vecs[12] = '{3'b110, 3'd5, 8'hCC, 8'hCC, 1'b1};
    vecs[13] = '{OP_SRA, 3'd0, 8'hCC, 8'hCC, 1'b0};
    vecs[14] = '{OP_SRL, 3'd0, 8'hCC, 8'hCC, 1'b0};
    vecs[15] = '{OP_SLL, 3'd0, 8'hCC, 8'hCC, 1'b0};
    vecs[16] = '{OP_ROR, 3'd0, 8'hCC, 8'hCC, 1'b0};
    vecs[17] = '{3'b111, 3'd0, 8'h5A, 8'h5A, 1'b1};
    vecs[18] = '{3'b101, 3'd7, 8'h3C, 8'h3C, 1'b1};
    vecs[19] = '{OP_SRA, 3'd3, 8'h4C, 8'h09, 1'b0};
    vecs[20] = '{OP_SRA, 3'd7, 8'hCC, 8'hFF, 1'b0};
    vecs[21] = '{OP_SLL, 3'd1, 8'h3C, 8'h78, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_w", out_valid_w, 0);
    check("rst_out_data_w", out_data_w, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ROL sweep back to back, latency 3 then one per cycle
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) send_vec(vecs[i]);
    wait_drain("drain_rol");

    // each mode, amt 0, illegal ops
    for (int i = 8; i < 22; i++) send_vec(vecs[i]);
    wait_drain("drain_modes");

    // back-pressure: 4-cycle stall after first out_valid
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send_vec(vecs[i]);
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          w++;
          @(negedge clk);
        end
        check("bp_valid_seen", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (i == 0) held = {out_err, out_data};
          check("bp_in_ready", in_ready, 0);
          check("bp_valid_held", out_valid, 1);
          if (i > 0) check("bp_data_stable", {out_err, out_data}, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // reset with three ops in flight
    chk_lat = 1'b1;
    send(OP_SLL, 3'd1, 8'hCC, {1'b0, 8'h98});
    send(OP_SRL, 3'd3, 8'hCC, {1'b0, 8'h19});
    send(OP_SRA, 3'd7, 8'hCC, {1'b0, 8'hFF});
    check("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_data", out_data, 0);
    check("rst_async_err", out_err, 0);
    exp_q.delete();
    stamp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(OP_ROR, 3'd5, 8'h81, {1'b0, 8'h0C});
    wait_drain("drain_post_rst");
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", out_valid, 0);

    // WIDTH = 32
    send32(OP_ROR, 5'd1,  32'h8000_0001, 32'hC000_0000);
    send32(OP_SRA, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF);
    send32(OP_SLL, 5'd31, 32'h8000_0001, 32'h8000_0000);
    send32(OP_ROL, 5'd4,  32'h8000_0001, 32'h0000_0018);
    send32(OP_SRL, 5'd31, 32'h8000_0001, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
